// File: rtl/echo_detector.sv
// Echo detector: power-of-two moving average, post-burst blanking, hysteresis threshold with N-sample confirmation.
// Optional peak tracking outputs are enabled by defining ECHO_PEAK_TRACK_EN.
module echo_detector #(
    parameter int unsigned SAMPLE_WIDTH  = 16,
    parameter int unsigned TIME_WIDTH    = 24,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned THRESHOLD_HI  = 500,
    parameter int unsigned THRESHOLD_LO  = 400,
    parameter int unsigned CONFIRM_COUNT = 4,
    parameter int unsigned BLANK_CYCLES  = 600000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    burst_start_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    input  logic [TIME_WIDTH-1:0]   time_in,
    output logic                    echo_valid_out,
    output logic [TIME_WIDTH-1:0]   echo_time_out,
    output logic [SAMPLE_WIDTH-1:0] echo_level_out,
    output logic                    no_echo_out,
    output logic                    armed_out
`ifdef ECHO_PEAK_TRACK_EN
    ,
    output logic [SAMPLE_WIDTH-1:0] peak_level_out,
    output logic [TIME_WIDTH-1:0]   peak_time_out
`endif
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = SAMPLE_WIDTH + AVG_LOG2;
    localparam int unsigned BC_W  = $clog2(BLANK_CYCLES + 1);
    localparam int unsigned CNT_W = $clog2(CONFIRM_COUNT + 1);

    localparam logic [SAMPLE_WIDTH-1:0] THR_HI     = SAMPLE_WIDTH'(THRESHOLD_HI);
    localparam logic [SAMPLE_WIDTH-1:0] THR_LO     = SAMPLE_WIDTH'(THRESHOLD_LO);
    localparam logic [BC_W-1:0]         BLANK_LAST = BC_W'((BLANK_CYCLES > 1) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]        CNT_DONE   = CNT_W'(CONFIRM_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ARMED,
        ST_CONFIRM,
        ST_LOCKED
    } state_t;

    state_t state_q, state_d;

    logic [SAMPLE_WIDTH-1:0] hist_q [DEPTH];
    logic [SAMPLE_WIDTH-1:0] hist_d [DEPTH];
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic [SAMPLE_WIDTH-1:0] avg_q, avg_d;
    logic [TIME_WIDTH-1:0]   avg_time_q, avg_time_d;
    logic                    avg_valid_q, avg_valid_d;
    logic                    accept;

    logic [BC_W-1:0]         blank_cnt_q, blank_cnt_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        cnt_inc;
    logic [TIME_WIDTH-1:0]   etime_q, etime_d;
    logic [SAMPLE_WIDTH-1:0] level_q, level_d;
    logic                    echo_valid_q, echo_valid_d;
    logic                    no_echo_q, no_echo_d;

`ifdef ECHO_PEAK_TRACK_EN
    logic [SAMPLE_WIDTH-1:0] peak_level_q, peak_level_d;
    logic [TIME_WIDTH-1:0]   peak_time_q, peak_time_d;
`endif

    // Blanked samples never reach the history, so the first armed average starts from zero.
    assign accept = sample_valid_in && !burst_start_in && (state_q != ST_BLANK);

    always_comb begin
        hist_d      = hist_q;
        sum_d       = sum_q;
        avg_d       = avg_q;
        avg_time_d  = avg_time_q;
        avg_valid_d = 1'b0;
        if (burst_start_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_d[i] = '0;
            end
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + SUM_W'(sample_in) - SUM_W'(hist_q[DEPTH-1]);
            hist_d[0] = sample_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            avg_d       = SAMPLE_WIDTH'(sum_d >> AVG_LOG2);
            avg_time_d  = time_in;
            avg_valid_d = 1'b1;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        blank_cnt_d  = blank_cnt_q;
        cnt_d        = cnt_q;
        etime_d      = etime_q;
        level_d      = level_q;
        echo_valid_d = 1'b0;
        no_echo_d    = 1'b0;
        if (burst_start_in) begin
            state_d     = ST_BLANK;
            blank_cnt_d = BC_W'(1);
            cnt_d       = '0;
            etime_d     = '0;
            level_d     = '0;
            no_echo_d   = (state_q == ST_ARMED) || (state_q == ST_CONFIRM);
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (blank_cnt_q >= BLANK_LAST) begin
                        state_d = ST_ARMED;
                    end else begin
                        blank_cnt_d = blank_cnt_q + BC_W'(1);
                    end
                end
                ST_ARMED: begin
                    if (avg_valid_q && (avg_q > THR_HI)) begin
                        etime_d = avg_time_q;
                        cnt_d   = CNT_W'(1);
                        if (CONFIRM_COUNT <= 1) begin
                            level_d      = avg_q;
                            echo_valid_d = 1'b1;
                            state_d      = ST_LOCKED;
                        end else begin
                            state_d = ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (avg_valid_q) begin
                        if (avg_q > THR_LO) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                level_d      = avg_q;
                                echo_valid_d = 1'b1;
                                state_d      = ST_LOCKED;
                            end
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_ARMED;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ECHO_PEAK_TRACK_EN
    always_comb begin
        peak_level_d = peak_level_q;
        peak_time_d  = peak_time_q;
        if (burst_start_in) begin
            peak_level_d = '0;
            peak_time_d  = '0;
        end else if (avg_valid_q && ((state_q == ST_CONFIRM) || (state_q == ST_LOCKED))
                     && (avg_q > peak_level_q)) begin
            peak_level_d = avg_q;
            peak_time_d  = avg_time_q;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            peak_level_q <= '0;
            peak_time_q  <= '0;
        end else begin
            peak_level_q <= peak_level_d;
            peak_time_q  <= peak_time_d;
        end
    end

    assign peak_level_out = peak_level_q;
    assign peak_time_out  = peak_time_q;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            sum_q        <= '0;
            avg_q        <= '0;
            avg_time_q   <= '0;
            avg_valid_q  <= 1'b0;
            state_q      <= ST_IDLE;
            blank_cnt_q  <= '0;
            cnt_q        <= '0;
            etime_q      <= '0;
            level_q      <= '0;
            echo_valid_q <= 1'b0;
            no_echo_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_q[i] <= hist_d[i];
            end
            sum_q        <= sum_d;
            avg_q        <= avg_d;
            avg_time_q   <= avg_time_d;
            avg_valid_q  <= avg_valid_d;
            state_q      <= state_d;
            blank_cnt_q  <= blank_cnt_d;
            cnt_q        <= cnt_d;
            etime_q      <= etime_d;
            level_q      <= level_d;
            echo_valid_q <= echo_valid_d;
            no_echo_q    <= no_echo_d;
        end
    end

    assign echo_valid_out = echo_valid_q;
    assign echo_time_out  = etime_q;
    assign echo_level_out = level_q;
    assign no_echo_out    = no_echo_q;
    assign armed_out      = (state_q == ST_ARMED) || (state_q == ST_CONFIRM);

endmodule

// File: tb/tb_echo_detector.sv
// Directed bench for echo_detector with a 2-sample average and 20-cycle blanking.
// Peak-tracking checks are compiled in when ECHO_PEAK_TRACK_EN is defined.
module tb_echo_detector;

    localparam int unsigned SW = 16;
    localparam int unsigned TW = 24;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          burst_start_in;
    logic [SW-1:0] sample_in;
    logic          sample_valid_in;
    logic [TW-1:0] time_in;
    logic          echo_valid_out;
    logic [TW-1:0] echo_time_out;
    logic [SW-1:0] echo_level_out;
    logic          no_echo_out;
    logic          armed_out;
`ifdef ECHO_PEAK_TRACK_EN
    logic [SW-1:0] peak_level_out;
    logic [TW-1:0] peak_time_out;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned tm      = 0;

    always #5 clk_in = ~clk_in;

    echo_detector #(
        .SAMPLE_WIDTH (SW),
        .TIME_WIDTH   (TW),
        .AVG_LOG2     (1),
        .THRESHOLD_HI (500),
        .THRESHOLD_LO (400),
        .CONFIRM_COUNT(4),
        .BLANK_CYCLES (20)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .burst_start_in (burst_start_in),
        .sample_in      (sample_in),
        .sample_valid_in(sample_valid_in),
        .time_in        (time_in),
        .echo_valid_out (echo_valid_out),
        .echo_time_out  (echo_time_out),
        .echo_level_out (echo_level_out),
        .no_echo_out    (no_echo_out),
        .armed_out      (armed_out)
`ifdef ECHO_PEAK_TRACK_EN
        ,
        .peak_level_out (peak_level_out),
        .peak_time_out  (peak_time_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // time_in counts cycles since the last burst: 0 on the burst cycle itself.
    task automatic drive(input logic b, input logic v, input logic [SW-1:0] s);
        burst_start_in  = b;
        sample_valid_in = v;
        sample_in       = s;
        time_in         = b ? '0 : TW'(tm);
        @(posedge clk_in);
        #1;
        tm = b ? 1 : tm + 1;
    endtask

    task automatic run_blank(input logic v, input logic [SW-1:0] s, input int first);
        for (int k = first; k <= 19; k++) begin
            drive(1'b0, v, s);
            check("blank_echo_valid", 32'(echo_valid_out), 0);
            if (k >= 18) check("armed_at_blank_end", 32'(armed_out), (k == 19) ? 1 : 0);
        end
    endtask

    initial begin
        logic [SW-1:0] seq3 [9];
        logic [SW-1:0] seq6 [7];
        seq3 = '{16'd0, 16'd1050, 16'd0, 16'd0, 16'd0, 16'd2000, 16'd0, 16'd0, 16'd0};
        seq6 = '{16'd1200, 16'd0, 16'd1800, 16'd0, 16'd1400, 16'd0, 16'd0};

        rst_in = 1'b1;
        burst_start_in = 1'b0;
        sample_valid_in = 1'b0;
        sample_in = '0;
        time_in = '0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_echo_valid", 32'(echo_valid_out), 0);
        check("rst_no_echo", 32'(no_echo_out), 0);
        check("rst_armed", 32'(armed_out), 0);
        check("rst_echo_time", 32'(echo_time_out), 0);
        check("rst_echo_level", 32'(echo_level_out), 0);
        rst_in = 1'b0;

        // Idle: samples without a burst never arm the detector.
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 16'd1000);
            check("idle_echo_valid", 32'(echo_valid_out), 0);
            check("idle_no_echo", 32'(no_echo_out), 0);
            check("idle_armed", 32'(armed_out), 0);
        end

        // Constant 1000: averages 500 then 1000; crossing at t=21, confirm on t=24 sample.
        drive(1'b1, 1'b0, 16'd0);
        check("idle_burst_no_echo", 32'(no_echo_out), 0);
        run_blank(1'b1, 16'd1000, 1);
        for (int k = 20; k <= 27; k++) begin
            drive(1'b0, 1'b1, 16'd1000);
            check("t2_echo_valid", 32'(echo_valid_out), (k == 25) ? 1 : 0);
            if (k == 24) check("t2_echo_time", 32'(echo_time_out), 21);
            if (k == 25) check("t2_echo_level", 32'(echo_level_out), 1000);
            if (k == 27) check("t2_locked_armed", 32'(armed_out), 0);
        end

        // Burst from LOCKED: no no_echo pulse, held outputs clear.
        drive(1'b1, 1'b0, 16'd0);
        check("locked_burst_no_echo", 32'(no_echo_out), 0);
        check("t3_time_clear", 32'(echo_time_out), 0);
        check("t3_level_clear", 32'(echo_level_out), 0);
        run_blank(1'b0, 16'd0, 1);
        for (int k = 20; k <= 28; k++) begin
            drive(1'b0, 1'b1, seq3[k-20]);
            check("t3_echo_valid", 32'(echo_valid_out), 0);
            if (k == 22) check("t3_first_time", 32'(echo_time_out), 21);
            if (k == 22 || k == 24 || k == 28) check("t3_armed", 32'(armed_out), 1);
            if (k == 26) check("t3_second_time", 32'(echo_time_out), 25);
        end

        // Burst from ARMED: no_echo pulses for exactly one cycle.
        drive(1'b1, 1'b0, 16'd0);
        check("t4_no_echo", 32'(no_echo_out), 1);
        check("t4_echo_valid", 32'(echo_valid_out), 0);
        check("t4_time_clear", 32'(echo_time_out), 0);
        check("t4_armed", 32'(armed_out), 0);
        drive(1'b0, 1'b0, 16'd0);
        check("t4_no_echo_end", 32'(no_echo_out), 0);
        run_blank(1'b0, 16'd0, 2);

        // Burst lands on the confirming avg_valid cycle: echo suppressed.
        for (int k = 20; k <= 24; k++) begin
            drive(1'b0, 1'b1, 16'd1000);
            check("t5_echo_valid", 32'(echo_valid_out), 0);
        end
        check("t5_time", 32'(echo_time_out), 21);
        check("t5_armed", 32'(armed_out), 1);
        drive(1'b1, 1'b0, 16'd0);
        check("t5_suppressed", 32'(echo_valid_out), 0);
        check("t5_no_echo", 32'(no_echo_out), 1);
        check("t5_armed_off", 32'(armed_out), 0);
        check("t5_time_clear", 32'(echo_time_out), 0);
        check("t5_level_clear", 32'(echo_level_out), 0);
        drive(1'b0, 1'b0, 16'd0);
        check("t5_late_echo", 32'(echo_valid_out), 0);
        check("t5_no_echo_end", 32'(no_echo_out), 0);
        run_blank(1'b0, 16'd0, 2);

        // Averages 600 (crossing), 600, 900, 900, 700.
        for (int k = 20; k <= 26; k++) begin
            drive(1'b0, 1'b1, seq6[k-20]);
            check("t6_echo_valid", 32'(echo_valid_out), (k == 24) ? 1 : 0);
        end
        check("t6_echo_time", 32'(echo_time_out), 20);
        check("t6_echo_level", 32'(echo_level_out), 900);
`ifdef ECHO_PEAK_TRACK_EN
        check("t6_peak_level", 32'(peak_level_out), 900);
        check("t6_peak_time", 32'(peak_time_out), 22);
        drive(1'b1, 1'b0, 16'd0);
        check("t6_peak_clear", 32'(peak_level_out), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_detector.md
Name: echo_detector

Overview:
Sits between receive_beamformer and time_of_flight. Consumes the aggregated receive waveform sample stream and smooths it with a power-of-two moving average. Applies post-burst blanking and a hysteresis threshold with N-sample confirmation. Emits one echo event per pulse period, carrying the emission-relative timestamp of the first threshold crossing.

Parameters:
SAMPLE_WIDTH, 16, width of incoming aggregated samples (unsigned)
TIME_WIDTH, 24, width of time-since-emission counter
AVG_LOG2, 2, moving-average depth = 2^AVG_LOG2 samples
THRESHOLD_HI, 500, averaged level that must be strictly exceeded to start a detection
THRESHOLD_LO, 400, averaged level that must be strictly exceeded to continue a detection (THRESHOLD_LO <= THRESHOLD_HI)
CONFIRM_COUNT, 4, consecutive qualifying averaged samples required, counting the first crossing
BLANK_CYCLES, 600000, clock cycles after burst_start_in during which samples are ignored (covers 524288-cycle burst plus ringdown)

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  asynchronous, active-high reset
burst_start_in  input  1  single-cycle pulse at the start of each emission period
sample_in  input  SAMPLE_WIDTH  aggregated receive sample
sample_valid_in  input  1  sample_in qualifier
time_in  input  TIME_WIDTH  cycles since emission
echo_valid_out  output  1  single-cycle pulse when an echo is confirmed
echo_time_out  output  TIME_WIDTH  time_in captured on the first-crossing sample; held until next burst_start_in
echo_level_out  output  SAMPLE_WIDTH  averaged level at confirmation; held
no_echo_out  output  1  single-cycle pulse: the period ended without a confirmed echo
armed_out  output  1  high in ARMED or CONFIRM

Behaviour:
- Reset (async): state IDLE. History, sum, counters and all outputs are 0.
- Averager:
  - Shift register of 2^AVG_LOG2 samples plus a running sum of width SAMPLE_WIDTH+AVG_LOG2.
  - On sample_valid_in: sum <= sum + sample_in - oldest. The average (sum >> AVG_LOG2) is registered 1 cycle after the valid sample, together with that sample's time_in.
  - A registered avg_valid strobe accompanies it.
  - burst_start_in zeroes the history and sum.
  - Samples arriving during blanking do not enter the history.
- FSM states:
  - IDLE: wait for burst_start_in.
  - BLANK: counter counts BLANK_CYCLES clock cycles from the burst_start_in cycle, then goes to ARMED.
  - ARMED: on avg_valid with avg > THRESHOLD_HI, capture the associated time into echo_time_out, set confirm count = 1, and go to CONFIRM. If CONFIRM_COUNT = 1, go straight to LOCKED instead.
  - CONFIRM, on avg_valid:
    - If avg > THRESHOLD_LO, increment the count. When the count reaches CONFIRM_COUNT, latch echo_level_out = avg, pulse echo_valid_out on the next cycle, and go to LOCKED.
    - Otherwise, return to ARMED with count = 0. echo_time_out is overwritten by the next crossing.
  - LOCKED: ignore samples until burst_start_in.
- Latency: echo_valid_out rises exactly 2 cycles after the sample_valid_in cycle of the confirming sample.
- burst_start_in in any state, including mid-CONFIRM:
  - next state BLANK, blank counter restarts;
  - echo_time_out and echo_level_out clear to 0;
  - count clears;
  - a pending echo_valid_out is suppressed.
- no_echo_out pulses in the cycle after burst_start_in if the state was ARMED or CONFIRM when burst_start_in arrived. No pulse from IDLE, BLANK or LOCKED.
- Comparisons are unsigned.
- The averager saturates nothing; the sum width guarantees no overflow.
- echo_valid_out and no_echo_out are never high in the same cycle.

Optional Feature:
ECHO_PEAK_TRACK_EN:
- Defined:
  - Adds outputs peak_level_out [SAMPLE_WIDTH] and peak_time_out [TIME_WIDTH], both cleared on burst_start_in.
  - Tracks the maximum avg seen while in CONFIRM or LOCKED, and the time of that avg.
  - Updates only on strictly greater values; on a tie the earliest time is kept.
  - Tracking stops at the next burst_start_in.
- Undefined: these ports and registers are absent. Other behaviour is identical.

Test Plan:
- Reset then no burst_start_in, constant samples 1000 valid every cycle -> state stays IDLE; echo_valid_out, no_echo_out and armed_out stay 0.
- BLANK_CYCLES=20; burst_start_in, samples 1000 from cycle 1 -> no detection before cycle 20; armed_out rises at cycle 20. With all-1000 samples, the crossing is the second post-blank sample (avg 500 after one sample is not > 500). echo_time_out = that sample's time_in; echo_valid_out fires 2 cycles after the 5th post-blank sample; echo_level_out = 1000.
- Armed; samples 0,0,0,2100 (avg 525, crossing), then 0 -> avg 525 > 400 counts; continue zeros until avg drops to 0 -> return to ARMED, no echo_valid_out; a later burst produces the crossing time of the new event.
- Armed, no qualifying samples, then burst_start_in -> no_echo_out pulses once the next cycle; state BLANK; echo_time_out = 0.
- burst_start_in arrives in the same cycle as the confirming avg_valid -> echo_valid_out is not asserted, state BLANK, outputs cleared.
- ECHO_PEAK_TRACK_EN: averaged levels 600, 900, 900, 700 after the crossing -> peak_level_out = 900; peak_time_out = time of the first 900.
